ov7725_cfg_sequencer: RTL

- Sequences OV7725 register configuration at power-up: waits for sensor power settle, walks the config LUT index range, and issues one SCCB write per entry to the shared SCCB/I2C write engine.
- Sits between the combinational config LUT (index out, 16-bit {reg,data} in) and the SCCB master; drives cfg_done to release the capture/SDRAM/VGA pipeline.
- Re-runnable on demand via cfg_restart.

---
 rtl/ov7725_cfg_pkg.sv | 34 +++
 rtl/cfg_delay_timer.sv | 36 +++
 rtl/ov7725_cfg_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ov7725_cfg_pkg.sv
// Shared types and defaults for the OV7725 power-up configuration sequencer.
// Optional feature macro: CFG_DELAY_MARKER_EN (LUT entries addressed 8'hFF become ms delays).
package ov7725_cfg_pkg;

    localparam int DLY_W = 20;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_NEXT,
        ST_DONE,
        ST_ERROR,
        ST_MARKER_WAIT
    } cfg_state_e;

    localparam logic [7:0]       DEV_ADDR_DEFAULT  = 8'h42;
    localparam logic [7:0]       DELAY_MARKER_ADDR = 8'hFF;
    localparam logic [DLY_W-1:0] PWR_DLY_DEFAULT   = 20'd1_000_000;

    // A delay of N cycles is realised by loading N-1; zero still costs one cycle.
    function automatic logic [DLY_W-1:0] dly_load(input logic [DLY_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - 1'b1;
    endfunction

    function automatic logic [DLY_W-1:0] ms_cycles(input logic [DLY_W-1:0] pwr_dly);
        logic [DLY_W-1:0] q;
        q = pwr_dly / DLY_W'(20);
        return (q == '0) ? DLY_W'(1) : q;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter with a zero flag; times the power settle and the ms delay markers.
module cfg_delay_timer
    import ov7725_cfg_pkg::*;
#(
    parameter logic [DLY_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [DLY_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/ov7725_cfg_sequencer.sv
// Walks the OV7725 config LUT after power settle, issuing one SCCB write (with retries) per entry.
// Optional feature macro: CFG_DELAY_MARKER_EN.
module ov7725_cfg_sequencer
    import ov7725_cfg_pkg::*;
#(
    parameter logic [7:0]       CFG_FIRST = 8'd2,
    parameter logic [7:0]       CFG_LAST  = 8'd4,
    parameter logic [7:0]       DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter logic [DLY_W-1:0] PWR_DLY   = PWR_DLY_DEFAULT,
    parameter logic [7:0]       RETRY_MAX = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_restart,
    output logic [7:0]  lut_index,
    input  logic [15:0] lut_data,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam logic [DLY_W-1:0] PWR_LOAD   = dly_load(PWR_DLY);
    localparam logic [7:0]       RETRY_LAST = RETRY_MAX - 8'd1;

    cfg_state_e       state_q, state_d;
    logic [7:0]       lut_index_q, lut_index_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       retry_q, retry_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             timer_load;
    logic [DLY_W-1:0] timer_load_val;
    logic             timer_en;
    logic             timer_done;

`ifdef CFG_DELAY_MARKER_EN
    localparam logic [DLY_W-1:0] MS_LOAD = dly_load(ms_cycles(PWR_DLY));
    logic [7:0] ms_left_q, ms_left_d;
`endif

    cfg_delay_timer #(
        .RST_VAL (PWR_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .done     (timer_done)
    );

    always_comb begin
        state_d        = state_q;
        lut_index_d    = lut_index_q;
        reg_addr_d     = reg_addr_q;
        wdata_d        = wdata_q;
        retry_d        = retry_q;
        req_d          = req_q;
        busy_d         = busy_q;
        done_d         = done_q;
        err_d          = err_q;
        timer_load     = 1'b0;
        timer_load_val = PWR_LOAD;
        timer_en       = 1'b0;
`ifdef CFG_DELAY_MARKER_EN
        ms_left_d      = ms_left_q;
`endif

        // Restart wins over everything, abandoning any transfer still owned by the engine.
        if (cfg_restart) begin
            state_d        = ST_PWR_WAIT;
            lut_index_d    = CFG_FIRST;
            retry_d        = 8'd0;
            req_d          = 1'b0;
            busy_d         = 1'b1;
            done_d         = 1'b0;
            err_d          = 1'b0;
            timer_load     = 1'b1;
            timer_load_val = PWR_LOAD;
        end else begin
            case (state_q)
                ST_PWR_WAIT: begin
                    timer_en = 1'b1;
                    if (timer_done) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    reg_addr_d = lut_data[15:8];
                    wdata_d    = lut_data[7:0];
                    retry_d    = 8'd0;
                    state_d    = ST_ISSUE;
`ifdef CFG_DELAY_MARKER_EN
                    if (lut_data[15:8] == DELAY_MARKER_ADDR) begin
                        if (lut_data[7:0] == 8'd0) begin
                            state_d = ST_NEXT;
                        end else begin
                            timer_load     = 1'b1;
                            timer_load_val = MS_LOAD;
                            ms_left_d      = lut_data[7:0];
                            state_d        = ST_MARKER_WAIT;
                        end
                    end
`endif
                end
                ST_ISSUE: begin
                    req_d   = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (i2c_done) begin
                        req_d = 1'b0;
                        if (!i2c_nack) begin
                            state_d = ST_NEXT;
                        end else if (retry_q < RETRY_LAST) begin
                            retry_d = retry_q + 8'd1;
                            state_d = ST_ISSUE;
                        end else begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_NEXT: begin
                    if (lut_index_q == CFG_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        lut_index_d = lut_index_q + 8'd1;
                        state_d     = ST_FETCH;
                    end
                end
`ifdef CFG_DELAY_MARKER_EN
                ST_MARKER_WAIT: begin
                    timer_en = 1'b1;
                    if (timer_done) begin
                        if (ms_left_q <= 8'd1) begin
                            state_d = ST_NEXT;
                        end else begin
                            ms_left_d      = ms_left_q - 8'd1;
                            timer_load     = 1'b1;
                            timer_load_val = MS_LOAD;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_PWR_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWR_WAIT;
            lut_index_q <= CFG_FIRST;
            reg_addr_q  <= 8'd0;
            wdata_q     <= 8'd0;
            retry_q     <= 8'd0;
            req_q       <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CFG_DELAY_MARKER_EN
            ms_left_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            lut_index_q <= lut_index_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef CFG_DELAY_MARKER_EN
            ms_left_q   <= ms_left_d;
`endif
        end
    end

    assign lut_index    = lut_index_q;
    assign i2c_req      = req_q;
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_reg_addr = reg_addr_q;
    assign i2c_wdata    = wdata_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;

endmodule
